// File: rtl/spi_lcd_sink.sv
// SPI receiver for an LCD controller command stream: decodes the column/page
// window commands and RAM writes, and emits RGB565 pixels with their coordinates.
module spi_lcd_sink #(
  parameter int H_RES = 240,
  parameter int V_RES = 320
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sclk,
  input  logic        i_mosi,
  input  logic        i_dc,
  input  logic        i_cs,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd,
  output logic        o_pix_valid,
  output logic [8:0]  o_pix_x,
  output logic [8:0]  o_pix_y,
  output logic [15:0] o_pix_data,
  output logic        o_frame_done,
  output logic        o_err
);

  typedef enum logic [1:0] {S_IDLE, S_COL, S_PAGE, S_RAM} state_t;

  logic       r_sclk_s1, r_sclk_s2, r_sclk_d, r_cs_s1, r_cs_s2;
  logic       r_mosi_s1, r_mosi_s2, r_dc_s1, r_dc_s2;
  logic [2:0] r_bitcnt;
  logic [6:0] r_shift;
  logic       r_vld_p0, r_dc_p0, r_vld_p1, r_dc_p1;
  logic [7:0] r_byte_p0, r_byte_p1;
  state_t     r_state, w_state_nxt;
  logic [1:0] r_pidx;
  logic [8:0] r_sh_start;
  logic       r_sh_end8;
  logic [8:0] r_xs, r_xe, r_ys, r_ye, r_cur_x, r_cur_y;
  logic       r_phase_lo;
  logic [7:0] r_hi;
  logic       w_sclk_rise, w_is_cmd, w_is_dat, w_win_bad, w_win_last;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;

  // Synchronizer stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
    end else begin
      r_sclk_s1 <= i_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_cs_s1   <= i_cs;
      r_cs_s2   <= r_cs_s1;
    end
  end

  always_ff @(posedge i_clk) begin
    r_mosi_s1 <= i_mosi;
    r_mosi_s2 <= r_mosi_s1;
    r_dc_s1   <= i_dc;
    r_dc_s2   <= r_dc_s1;
  end

  // Stage p0: bit assembly; a byte completes on the 8th rising SCLK edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bitcnt <= 3'd0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= 1'b0;
      if (r_cs_s2) begin
        r_bitcnt <= 3'd0;
      end else if (w_sclk_rise) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) r_vld_p0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_sclk_rise) begin
      r_shift <= {r_shift[5:0], r_mosi_s2};
      if (r_bitcnt == 3'd7) begin
        r_byte_p0 <= {r_shift, r_mosi_s2};
        r_dc_p0   <= r_dc_s2;
      end
    end
  end

  // Stage p1: byte handed to the decoder
  always_ff @(posedge i_clk) begin
    if (i_rst) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= r_vld_p0;
  end

  always_ff @(posedge i_clk) begin
    r_byte_p1 <= r_byte_p0;
    r_dc_p1   <= r_dc_p0;
  end

  assign w_is_cmd   = r_vld_p1 & ~r_dc_p1;
  assign w_is_dat   = r_vld_p1 & r_dc_p1;
  assign w_win_bad  = (r_xs > r_xe) || (r_ys > r_ye);
  assign w_win_last = (r_pidx == 2'd3);

  always_comb begin
    w_state_nxt = r_state;
    if (w_is_cmd) begin
      case (r_byte_p1)
        8'h2A:   w_state_nxt = S_COL;
        8'h2B:   w_state_nxt = S_PAGE;
        8'h2C:   w_state_nxt = w_win_bad ? S_IDLE : S_RAM;
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_is_dat && (r_state == S_COL || r_state == S_PAGE) && w_win_last) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Stage p2: decoder and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_pidx       <= 2'd0;
      r_xs         <= 9'd0;
      r_xe         <= 9'(H_RES - 1);
      r_ys         <= 9'd0;
      r_ye         <= 9'(V_RES - 1);
      r_cur_x      <= 9'd0;
      r_cur_y      <= 9'd0;
      r_phase_lo   <= 1'b0;
      o_cmd_valid  <= 1'b0;
      o_cmd        <= 8'd0;
      o_pix_valid  <= 1'b0;
      o_pix_x      <= 9'd0;
      o_pix_y      <= 9'd0;
      o_pix_data   <= 16'd0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      o_cmd_valid  <= 1'b0;
      o_pix_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
      if (w_is_cmd) begin
        o_cmd_valid <= 1'b1;
        o_cmd       <= r_byte_p1;
        r_pidx      <= 2'd0;
        r_phase_lo  <= 1'b0;
        if (r_byte_p1 == 8'h2C) begin
          if (w_win_bad) begin
            o_err <= 1'b1;
          end else begin
            r_cur_x <= r_xs;
            r_cur_y <= r_ys;
          end
        end
      end else if (w_is_dat) begin
        case (r_state)
          S_COL, S_PAGE: begin
            r_pidx <= r_pidx + 2'd1;
            if (w_win_last) begin
              if (r_state == S_COL) begin
                r_xs <= r_sh_start;
                r_xe <= {r_sh_end8, r_byte_p1};
              end else begin
                r_ys <= r_sh_start;
                r_ye <= {r_sh_end8, r_byte_p1};
              end
            end
          end
          S_RAM: begin
            r_phase_lo <= ~r_phase_lo;
            if (r_phase_lo) begin
              o_pix_valid <= 1'b1;
              o_pix_x     <= r_cur_x;
              o_pix_y     <= r_cur_y;
              o_pix_data  <= {r_hi, r_byte_p1};
              if (r_cur_x != r_xe) begin
                r_cur_x <= r_cur_x + 9'd1;
              end else begin
                r_cur_x <= r_xs;
                if (r_cur_y != r_ye) begin
                  r_cur_y <= r_cur_y + 9'd1;
                end else begin
                  r_cur_y      <= r_ys;
                  o_frame_done <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Window parameter shadow and pending high byte carry no control meaning
  always_ff @(posedge i_clk) begin
    if (w_is_dat) begin
      if (r_state == S_COL || r_state == S_PAGE) begin
        case (r_pidx)
          2'd0:    r_sh_start[8]   <= r_byte_p1[0];
          2'd1:    r_sh_start[7:0] <= r_byte_p1;
          2'd2:    r_sh_end8       <= r_byte_p1[0];
          default: ;
        endcase
      end
      if (r_state == S_RAM && !r_phase_lo) r_hi <= r_byte_p1;
    end
  end

endmodule

// File: tb/tb_spi_lcd_sink.sv
// Bench for spi_lcd_sink: randomized SPI byte timing and pixel data, with
// expected events computed from window arithmetic in a reference model.
module tb_spi_lcd_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0, mosi = 1'b0, dc = 1'b0, cs = 1'b1;
  logic        cmd_valid, pix_valid, frame_done, err;
  logic [7:0]  cmd;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_data;

  spi_lcd_sink #(.H_RES(240), .V_RES(320)) dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_mosi(mosi), .i_dc(dc), .i_cs(cs),
    .o_cmd_valid(cmd_valid), .o_cmd(cmd), .o_pix_valid(pix_valid),
    .o_pix_x(pix_x), .o_pix_y(pix_y), .o_pix_data(pix_data),
    .o_frame_done(frame_done), .o_err(err)
  );

  always #5 clk = ~clk;

  // kind: 0 command, 1 pixel, 2 window error, 3 stray frame_done
  typedef struct packed {
    logic [1:0]  kind;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
    logic        fd;
    logic [31:0] t;
  } ev_t;

  ev_t q_exp[$];
  ev_t q_obs[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic ev_t mk(input int kind, input int x, input int y, input int d,
                             input bit fd, input longint t);
    ev_t e;
    e.kind = 2'(kind); e.x = 9'(x); e.y = 9'(y); e.d = 16'(d); e.fd = fd; e.t = 32'(t);
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (cmd_valid) q_obs.push_back(mk(0, 0, 0, int'(cmd), 1'b0, $time - 1));
    if (err)       q_obs.push_back(mk(2, 0, 0, 0, 1'b0, $time - 1));
    if (pix_valid) q_obs.push_back(mk(1, int'(pix_x), int'(pix_y), int'(pix_data), frame_done, $time - 1));
    if (frame_done && !pix_valid) q_obs.push_back(mk(3, 0, 0, 0, 1'b1, $time - 1));
  end

  // Reference model: mode 0 idle, 1 column, 2 page, 3 RAM write
  int        m_mode, m_pi, m_pcnt;
  int        m_xs, m_xe, m_ys, m_ye;
  int        m_sh[4];
  bit        m_hi_ok;
  int        m_hi;

  task automatic model_reset();
    m_mode = 0; m_pi = 0; m_pcnt = 0; m_hi_ok = 0; m_hi = 0;
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
  endtask

  task automatic model_byte(input logic d, input logic [7:0] b, input longint t8);
    longint tp;
    int w, h, n;
    tp = t8 + 40;
    if (!d) begin
      q_exp.push_back(mk(0, 0, 0, int'(b), 1'b0, tp));
      m_hi_ok = 0;
      m_pi = 0;
      if (b == 8'h2A) m_mode = 1;
      else if (b == 8'h2B) m_mode = 2;
      else if (b == 8'h2C) begin
        if (m_xs > m_xe || m_ys > m_ye) begin
          q_exp.push_back(mk(2, 0, 0, 0, 1'b0, tp));
          m_mode = 0;
        end else begin
          m_mode = 3;
          m_pcnt = 0;
        end
      end else m_mode = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_sh[m_pi] = int'(b);
      m_pi++;
      if (m_pi == 4) begin
        if (m_mode == 1) begin
          m_xs = (m_sh[0] * 256 + m_sh[1]) % 512;
          m_xe = (m_sh[2] * 256 + m_sh[3]) % 512;
        end else begin
          m_ys = (m_sh[0] * 256 + m_sh[1]) % 512;
          m_ye = (m_sh[2] * 256 + m_sh[3]) % 512;
        end
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (!m_hi_ok) begin
        m_hi = int'(b);
        m_hi_ok = 1;
      end else begin
        w = m_xe - m_xs + 1;
        h = m_ye - m_ys + 1;
        n = m_pcnt % (w * h);
        q_exp.push_back(mk(1, m_xs + n % w, m_ys + n / w, m_hi * 256 + int'(b),
                           n == w * h - 1, tp));
        m_pcnt++;
        m_hi_ok = 0;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic d,
                           output longint t8);
    t8 = 0;
    tick(1);
    cs = 1'b0;
    dc = d;
    tick(2);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7 - i];
      tick(int'($urandom_range(2, 3)));
      sclk = 1'b1;
      if (i == 7) t8 = longint'($time) + 5;
      tick(int'($urandom_range(2, 3)));
      sclk = 1'b0;
    end
    tick(2);
    cs = 1'b1;
    tick(2);
  endtask

  task automatic send_byte(input logic d, input logic [7:0] b);
    longint t8;
    send_bits(b, 8, d, t8);
    model_byte(d, b, t8);
  endtask

  task automatic send_pixels(input int n);
    logic [15:0] px;
    for (int i = 0; i < n; i++) begin
      px = 16'($urandom);
      send_byte(1'b1, px[15:8]);
      send_byte(1'b1, px[7:0]);
    end
  endtask

  task automatic check_q(input string tag);
    tick(6);
    n_cmp++;
    assert (q_obs.size() === q_exp.size()) else begin
      n_bad++;
      $error("FAIL %s event count: observed %0d expected %0d", tag, q_obs.size(), q_exp.size());
    end
    for (int i = 0; i < q_exp.size() && i < q_obs.size(); i++) begin
      n_cmp++;
      assert (q_obs[i] === q_exp[i]) else begin
        n_bad++;
        $error("FAIL %s event %0d: observed kind=%0d x=%0d y=%0d d=%h fd=%b t=%0d expected kind=%0d x=%0d y=%0d d=%h fd=%b t=%0d",
               tag, i, q_obs[i].kind, q_obs[i].x, q_obs[i].y, q_obs[i].d, q_obs[i].fd, q_obs[i].t,
               q_exp[i].kind, q_exp[i].x, q_exp[i].y, q_exp[i].d, q_exp[i].fd, q_exp[i].t);
      end
    end
    q_obs.delete();
    q_exp.delete();
  endtask

  task automatic check_zero(input string tag);
    logic [60:0] v;
    v = {cmd_valid, cmd, pix_valid, pix_x, pix_y, pix_data, frame_done, err};
    n_cmp++;
    assert (v === 61'd0) else begin
      n_bad++;
      $error("FAIL %s outputs: observed %h expected 0", tag, v);
    end
  endtask

  initial begin
    longint tdummy;
    int xs, w, ys, h;
    model_reset();
    tick(5);
    check_zero("reset_state");
    rst = 1'b0;
    tick(3);
    check_zero("after_release");

    // Window setup
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h28); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'hC7);
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h50); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h50);
    check_q("window_cmds");

    // First pixel of the window
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hF8); send_byte(1'b1, 8'h00);
    check_q("first_pixel");

    // Complete the row (frame_done on x=199) and wrap
    send_pixels(160);
    check_q("row_wrap");

    // Partial byte discarded, then command; pending high byte discarded by a command
    send_bits(8'hA5, 5, 1'b0, tdummy);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h12);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hAB); send_byte(1'b1, 8'hCD);
    check_q("partial_and_pending");

    // Aborted page command keeps the committed rows
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
    send_byte(1'b0, 8'h2C);
    send_pixels(2);
    check_q("aborted_page");

    // Invalid column window
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'hC8); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h10);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22);
    check_q("bad_window");

    // Random small window, full frame plus wrap
    xs = int'($urandom_range(0, 300)); w = int'($urandom_range(1, 4));
    ys = int'($urandom_range(0, 300)); h = int'($urandom_range(1, 3));
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'(xs >> 8)); send_byte(1'b1, 8'(xs));
    send_byte(1'b1, 8'((xs + w - 1) >> 8)); send_byte(1'b1, 8'(xs + w - 1));
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'(ys >> 8)); send_byte(1'b1, 8'(ys));
    send_byte(1'b1, 8'((ys + h - 1) >> 8)); send_byte(1'b1, 8'(ys + h - 1));
    send_byte(1'b0, 8'h2C);
    send_pixels(w * h + 2);
    check_q("random_window");

    // Reset mid-frame and mid-byte
    send_byte(1'b0, 8'h2C);
    send_pixels(50);
    check_q("pre_reset");
    tick(1);
    cs = 1'b0; dc = 1'b1; tick(3);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1; tick(2); sclk = 1'b1; tick(2); sclk = 1'b0;
    end
    rst = 1'b1;
    tick(3);
    check_zero("mid_frame_reset");
    cs = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(3);
    check_zero("post_reset_quiet");
    check_q("reset_no_pulse");

    // Default window after reset: origin then wrap past x=239
    send_byte(1'b0, 8'h2C);
    send_pixels(241);
    check_q("default_window");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_lcd_sink.md
SPI_LCD_SINK -- requirements
Module: spi_lcd_sink

Interface
REQ-001 SHALL have parameter H_RES, default 240, display width in pixels; sets the reset value of the column window.
REQ-002 SHALL have parameter V_RES, default 320, display height in pixels; sets the reset value of the page window.
REQ-003 SHALL have port i_clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_sclk  input  1  SPI serial clock, asynchronous to i_clk.
REQ-006 SHALL have port i_mosi  input  1  SPI serial data, MSB first, mode 0.
REQ-007 SHALL have port i_dc  input  1  0 = command byte, 1 = data byte.
REQ-008 SHALL have port i_cs  input  1  chip select, active-low.
REQ-009 SHALL have port o_cmd_valid  output  1  one-cycle pulse when a command byte completes.
REQ-010 SHALL have port o_cmd  output  8  last command byte received.
REQ-011 SHALL have port o_pix_valid  output  1  one-cycle pulse per completed RGB565 pixel.
REQ-012 SHALL have port o_pix_x / o_pix_y  output  9 each  pixel coordinates.
REQ-013 SHALL have port o_pix_data  output  16  pixel value {high byte, low byte}.
REQ-014 SHALL have port o_frame_done  output  1  one-cycle pulse when the last pixel of the window is written.
REQ-015 SHALL have port o_err  output  1  one-cycle pulse when 0x2C is received with an invalid window.

Function
REQ-016 SHALL pass i_sclk, i_mosi, i_dc and i_cs through 2-FF synchronizers, then detect SCLK rising edges in the i_clk domain. The environment guarantees SCLK high and low phases each last at least 2 i_clk cycles.
REQ-017 SHALL shift i_mosi MSB-first on each synchronized SCLK rising edge while CS is low, and SHALL sample DC on the 8th bit.
REQ-018 SHALL clear the bit counter whenever synchronized CS is high, discarding a partial byte with no output. Decoder state, window registers and pixel phase SHALL persist across CS high, because the transmitter deasserts CS between bytes.
REQ-019 SHALL assert o_cmd_valid and o_pix_valid exactly 4 i_clk edges after the i_clk edge that first samples the 8th SCLK bit high.
REQ-020 SHALL implement the decoder FSM with states IDLE, COL, PAGE, RAM. Any command byte exits the current state, then:
  - 0x2A: go to COL, parameter index 0.
  - 0x2B: go to PAGE, parameter index 0.
  - 0x2C: go to RAM.
  - any other command: go to IDLE.
REQ-021 In COL and PAGE, SHALL collect 4 data bytes into a shadow register as start_hi, start_lo, end_hi, end_lo.
  - On the 4th byte: commit bits [8:0] of start and end to XS/XE (COL) or YS/YE (PAGE), then go to IDLE.
  - A command arriving before the 4th byte leaves the committed registers unchanged.
REQ-022 In IDLE, data bytes SHALL be ignored.
REQ-023 On entry to RAM, SHALL load cur_x = XS, cur_y = YS and set the byte phase to high. If XS > XE or YS > YE, SHALL instead pulse o_err and go to IDLE.
REQ-024 In RAM, SHALL handle data bytes by byte phase:
  - High phase: latch the byte.
  - Low phase: pulse o_pix_valid with o_pix_x = cur_x, o_pix_y = cur_y, o_pix_data = {hi, lo}.
REQ-025 After each pixel, SHALL advance the position:
  - If cur_x ≠ XE: cur_x + 1.
  - Else if cur_y ≠ YE: cur_x = XS, cur_y + 1.
  - Else: cur_x = XS, cur_y = YS, and pulse o_frame_done in the same cycle as o_pix_valid.
REQ-026 A command received while a high byte is pending SHALL discard that byte.
REQ-027 o_pix_x, o_pix_y, o_pix_data and o_cmd SHALL hold their values between pulses.

Reset
REQ-028 On i_rst, SHALL set all outputs to 0, the FSM to IDLE, the bit counter to 0, XS = 0, XE = H_RES-1, YS = 0, YE = V_RES-1 and the byte phase to high.
REQ-029 Reset asserted mid-byte or mid-frame SHALL abort all activity with no output pulse, and decoding SHALL restart from the next byte after reset release.

Verification
REQ-030 Scenario: send 0x2A, 00 28 00 C7, then 0x2B, 00 50 00 50 -> o_cmd_valid pulses twice (o_cmd = 2A, then 2B); XS = 40, XE = 199, YS = YE = 80.
REQ-031 Scenario: with that window, send 0x2C then F8 00 -> one o_pix_valid with x = 40, y = 80, data = F800, 4 cycles after the last SCLK edge.
REQ-032 Scenario: send 160 pixels -> last pixel at x = 199, y = 80 with o_frame_done in the same cycle; the 161st pixel lands at x = 40, y = 80.
REQ-033 Scenario: raise CS after 5 bits of a byte, then send a full 0x2C -> no pulse for the partial byte; o_cmd = 2C.
REQ-034 Scenario: send 0x2A, 00 C8 00 10, then 0x2C -> o_err pulses and no pixels are produced for following data bytes.
REQ-035 Scenario: assert i_rst after 50 pixels -> all outputs are 0 and XE = H_RES-1; after 0x2C plus one pixel, the pixel lands at x = 0, y = 0.
